// File: rtl/collision_detector.sv
// rtl/collision_detector.sv - per-lane frog/car collision FSM with lives and post-hit grace window.
// Optional build macro COLLISION_REQUIRE_CLEAR_EN adds a CLEAR state so a parked frog is hit only once.
module collision_detector #(
    parameter int LIVES       = 3,
    parameter int GRACE_WIDTH = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] lane_pixels,
    input  logic        frog_in_lane,
    input  logic [15:0] frog_col,
    output logic        hit_pulse,
    output logic        game_over,
    output logic [2:0]  lives,
    output logic        armed
);

`ifdef COLLISION_REQUIRE_CLEAR_EN
    typedef enum logic [1:0] {ST_ALIVE, ST_GRACE, ST_DEAD, ST_CLEAR} state_t;
`else
    typedef enum logic [1:0] {ST_ALIVE, ST_GRACE, ST_DEAD} state_t;
`endif

    // Leaving on the cycle that would count to all-ones gives a grace of 2^W-1 cycles.
    localparam logic [GRACE_WIDTH-1:0] GRACE_MAX  = '1;
    localparam logic [GRACE_WIDTH-1:0] GRACE_LAST = GRACE_MAX - GRACE_WIDTH'(1);

    state_t                 state_q, state_d;
    logic [2:0]             lives_q, lives_d;
    logic                   hit_q, hit_d;
    logic [GRACE_WIDTH-1:0] grace_q, grace_d;
    logic                   overlap;

    assign overlap = frog_in_lane & (|(lane_pixels & frog_col));

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        hit_d   = 1'b0;
        grace_d = grace_q;
        case (state_q)
            ST_ALIVE: begin
                if (overlap && lives_q != 3'd0) begin
                    hit_d   = 1'b1;
                    lives_d = lives_q - 3'd1;
                    grace_d = '0;
                    state_d = (lives_q == 3'd1) ? ST_DEAD : ST_GRACE;
                end
            end
            ST_GRACE: begin
                if (grace_q == GRACE_LAST) begin
                    grace_d = '0;
`ifdef COLLISION_REQUIRE_CLEAR_EN
                    state_d = ST_CLEAR;
`else
                    state_d = ST_ALIVE;
`endif
                end else begin
                    grace_d = grace_q + GRACE_WIDTH'(1);
                end
            end
`ifdef COLLISION_REQUIRE_CLEAR_EN
            ST_CLEAR: begin
                if (!overlap) begin
                    state_d = ST_ALIVE;
                end
            end
`endif
            ST_DEAD: begin
                lives_d = 3'd0;
            end
            default: begin
                state_d = ST_ALIVE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_ALIVE;
            lives_q <= 3'(LIVES);
            hit_q   <= 1'b0;
            grace_q <= '0;
        end else begin
            state_q <= state_d;
            lives_q <= lives_d;
            hit_q   <= hit_d;
            grace_q <= grace_d;
        end
    end

    assign hit_pulse = hit_q;
    assign game_over = (state_q == ST_DEAD);
    assign armed     = (state_q == ST_ALIVE);
    assign lives     = lives_q;

endmodule
